// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory boot loader.
// Purely declarative: no logic, no latency, no flow control.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, stop-bit check.
// byte_valid_out pulses ~2 clks after the stop-bit mid sample; no backpressure (consumer must take it).
module uart_rx_byte
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic       rx_in,
  output logic [7:0] byte_out,
  output logic       byte_valid_out,
  output logic       frame_err_out
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  rx_state_t               state, state_nxt;
  logic                    rx_meta, rx_sync, rx_prev;
  logic [CW-1:0]           cnt;
  logic [2:0]              bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                    cnt_full, cnt_half;

  assign cnt_full = (cnt == CW'(CLKS_PER_BIT - 1));
  assign cnt_half = (cnt == CW'(CLKS_PER_BIT / 2 - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (rx_prev && !rx_sync) state_nxt = RX_START;
      RX_START: if (cnt_half) state_nxt = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt_full && bit_idx == 3'(UART_DATA_BITS - 1)) state_nxt = RX_STOP;
      RX_STOP:  if (cnt_full) state_nxt = RX_IDLE;
      default:  state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      rx_meta        <= 1'b1;
      rx_sync        <= 1'b1;
      rx_prev        <= 1'b1;
      state          <= RX_IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      shift          <= '0;
      byte_out       <= '0;
      byte_valid_out <= 1'b0;
      frame_err_out  <= 1'b0;
    end else begin
      rx_meta        <= rx_in;
      rx_sync        <= rx_meta;
      rx_prev        <= rx_sync;
      state          <= state_nxt;
      byte_valid_out <= 1'b0;
      frame_err_out  <= 1'b0;
      // Counter restarts on every state change so each phase times from its own entry.
      if (state == RX_IDLE || state != state_nxt || cnt_full) cnt <= '0;
      else cnt <= cnt + CW'(1);
      if (state == RX_START) bit_idx <= '0;
      if (state == RX_DATA && cnt_full) begin
        shift   <= {rx_sync, shift[UART_DATA_BITS-1:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (state == RX_STOP && cnt_full) begin
        if (rx_sync) begin
          byte_out       <= shift;
          byte_valid_out <= 1'b1;
        end else begin
          frame_err_out  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// UART boot loader: header N then 4*N LE bytes -> IMEM writes; holds CPU until done. Option: LOADER_CHECKSUM_EN.
// One-cycle write strobe the clock after a word's 4th byte; no backpressure (IMEM always accepts).
module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH   = 6,
  parameter int INST_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic                  rx_in,
  output logic [ADDR_WIDTH-1:0] imem_addr_out,
  output logic [INST_WIDTH-1:0] imem_wdata_out,
  output logic                  imem_we_out,
  output logic                  cpu_hold_out,
  output logic                  load_done_out,
  output logic                  error_out,
  output logic                  frame_err_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  loader_state_t         state, state_nxt;
  logic [7:0]            rx_byte;
  logic                  rx_vld, rx_ferr;
  logic [CW-1:0]         n_words, word_idx;
  logic [1:0]            byte_idx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [INST_WIDTH-1:0] wdata;
  logic                  frame_err;
  logic                  hdr_zero, hdr_bad, word_last, last_byte;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk            (clk),
    .reset_in       (reset_in),
    .rx_in          (rx_in),
    .byte_out       (rx_byte),
    .byte_valid_out (rx_vld),
    .frame_err_out  (rx_ferr)
  );

  assign hdr_zero  = (rx_byte == 8'd0);
  assign hdr_bad   = ({24'd0, rx_byte} > 32'(DEPTH));
  assign word_last = ((word_idx + CW'(1)) == n_words);
  assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (rx_vld && !hdr_zero) state_nxt = hdr_bad ? ERROR : LOAD;
      LOAD:       if (rx_vld && last_byte) state_nxt = WRITE;
`ifdef LOADER_CHECKSUM_EN
      WRITE:      state_nxt = word_last ? CHECK : LOAD;
      CHECK:      if (rx_vld) state_nxt = (rx_byte == csum) ? DONE : ERROR;
`else
      WRITE:      state_nxt = word_last ? DONE : LOAD;
`endif
      ERROR:      state_nxt = ERROR;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state     <= IDLE;
      n_words   <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      addr      <= '0;
      wdata     <= '0;
      frame_err <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state     <= state_nxt;
      frame_err <= frame_err | rx_ferr;
      case (state)
        IDLE, DONE: begin
          if (rx_vld && !hdr_zero && !hdr_bad) begin
            n_words  <= CW'(rx_byte);
            word_idx <= '0;
            byte_idx <= '0;
            addr     <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        LOAD: begin
          if (rx_vld) begin
            wdata[{byte_idx, 3'b000} +: 8] <= rx_byte;
            byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum     <= csum ^ rx_byte;
`endif
            // Address is captured here so it is already stable during the WRITE cycle.
            if (last_byte) addr <= word_idx[ADDR_WIDTH-1:0];
          end
        end
        WRITE: word_idx <= word_idx + CW'(1);
        default: ;
      endcase
    end
  end

  assign imem_addr_out  = addr;
  assign imem_wdata_out = wdata;
  assign imem_we_out    = (state == WRITE);
  assign cpu_hold_out   = (state != DONE);
  assign load_done_out  = (state == DONE);
  assign error_out      = (state == ERROR);
  assign frame_err_out  = frame_err;

endmodule
